// File: rtl/ram_port_pkg.sv
// Shared types for the ram_port load/store bridge:
// access size encodings, FSM states and alignment helpers.
package ram_port_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RDATA,
    RESP
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SIZE_H && off[0]) ||
           (size == SIZE_W && off != 2'b00);
  endfunction

  // Clears the low offset bits an access of this size cannot use.
  function automatic logic [1:0] align_off(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [1:0] r;
    r = off;
    if (size == SIZE_H) r[0] = 1'b0;
    if (size == SIZE_W) r = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/ram_port_lane.sv
// Byte-lane steering, purely combinational.
// size/off/uns in; be, wrep (store) and rdata (load) out.
module ram_port_lane
  import ram_port_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] q,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be    = 4'b0000;
    wrep  = wdata;
    rdata = 32'h0;
    b     = q[{off, 3'b000} +: 8];
    h     = q[{off[1], 4'b0000} +: 16];
    unique case (1'b1)
      (size == SIZE_B): begin
        be    = 4'b0001 << off;
        wrep  = {4{wdata[7:0]}};
        rdata = {{24{~uns & b[7]}}, b};
      end
      (size == SIZE_H): begin
        be    = 4'b0011 << {off[1], 1'b0};
        wrep  = {2{wdata[15:0]}};
        rdata = {{16{~uns & h[15]}}, h};
      end
      (size == SIZE_W): begin
        be    = 4'b1111;
        rdata = q;
      end
      (size == SIZE_X): begin
        be    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/ram_port.sv
// CPU load/store to byte-enabled block RAM bridge (valid/ready req, held resp).
// RAM_PORT_ALIGN_CHECK_EN: misaligned accesses error instead of being aligned.
module ram_port
  import ram_port_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [3:0]               ram_we,
  output logic [ADDRESS_WIDTH-3:0] ram_addr,
  output logic [31:0]              ram_data,
  input  logic [31:0]              ram_q
);

  state_t                   state;
  logic [ADDRESS_WIDTH-3:0] addr_q;
  logic [1:0]               off_q;
  logic [1:0]               size_q;
  logic                     uns_q;
  logic                     err_q;

  logic        idle;
  logic [1:0]  off_in;
  logic        err_in;
  logic [1:0]  l_size;
  logic [1:0]  l_off;
  logic [3:0]  l_be;
  logic [31:0] l_rdata;
  logic        unused_hi;

  assign unused_hi = ^req_addr[31:ADDRESS_WIDTH];

`ifdef RAM_PORT_ALIGN_CHECK_EN
  assign off_in = req_addr[1:0];
  assign err_in = (req_size == SIZE_X) ||
                  misaligned(req_size, req_addr[1:0]);
`else
  assign off_in = align_off(req_size, req_addr[1:0]);
  assign err_in = (req_size == SIZE_X);
`endif

  assign idle      = (state == IDLE);
  assign req_ready = idle;

  // One lane unit: request fields drive it in IDLE, saved fields in RDATA.
  assign l_size = idle ? req_size : size_q;
  assign l_off  = idle ? off_in : off_q;

  ram_port_lane u_lane (
    .size  (l_size),
    .off   (l_off),
    .uns   (uns_q),
    .wdata (req_wdata),
    .q     (ram_q),
    .be    (l_be),
    .wrep  (ram_data),
    .rdata (l_rdata)
  );

  assign ram_we = (rst_n && idle && req_valid && req_we && !err_in)
                ? l_be : 4'b0000;
  assign ram_addr = idle ? req_addr[ADDRESS_WIDTH-1:2] : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr[ADDRESS_WIDTH-1:2];
            off_q  <= off_in;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            err_q  <= err_in;
            if (req_we) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= 32'h0;
              resp_err   <= err_in;
            end else begin
              state <= RDATA;
            end
          end
        end
        RDATA: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= err_q ? 32'h0 : l_rdata;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
